// File: rtl/stack_arb.sv
// stack_arb: round-robin push/pop arbiter and strobe sequencer for a negedge-clocked register stack.
// Build option: define STACK_ARB_CLR_EN to honour clr_i (re-clear the stack from IDLE).
module stack_arb #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       req_a_i,
  input  logic                       req_b_i,
  input  logic                       op_a_i,
  input  logic                       op_b_i,
  input  logic [WIDTH-1:0]           dat_a_i,
  input  logic [WIDTH-1:0]           dat_b_i,
  output logic                       ack_a_o,
  output logic                       ack_b_o,
  output logic                       err_a_o,
  output logic                       err_b_o,
  output logic [WIDTH-1:0]           rdat_o,
  input  logic [DEPTH*WIDTH-1:0]     stk_rows_i,
  output logic                       stk_w2_o,
  output logic                       stk_w1_o,
  output logic [WIDTH-1:0]           stk_din_o,
  output logic                       stk_clk_o,
  output logic                       stk_rst_o,
  output logic [$clog2(DEPTH+1)-1:0] depth_o,
  output logic                       full_o,
  output logic                       empty_o,
  input  logic                       clr_i
);

  localparam int DW = $clog2(DEPTH + 1);
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [2:0] {INIT0, INIT1, IDLE, SETUP, STROBE, HOLD, REJ} state_e;

  state_e           state_q;
  logic             rr_q;
  logic             sel_b_q;
  logic             ack_a_q, ack_b_q, err_a_q, err_b_q;
  logic [WIDTH-1:0] rdat_q;
  logic             stk_w2_q, stk_w1_q, stk_clk_q, stk_rst_q;
  logic [WIDTH-1:0] stk_din_q;
  logic [DW-1:0]    depth_q;

  logic [WIDTH-1:0] rows [DEPTH];
  logic             any_req, sel_b, sel_op, legal;
  logic [WIDTH-1:0] sel_dat;
  logic [IW-1:0]    top_idx;
  logic [DW-1:0]    depth_d;

`ifdef STACK_ARB_CLR_EN
`else
  logic unused_clr;
  assign unused_clr = clr_i;
`endif

  always_comb begin
    for (int k = 0; k < DEPTH; k++) begin
      rows[k] = stk_rows_i[k*WIDTH +: WIDTH];
    end
  end

  // With both requesters active the round-robin pointer (1 = B) picks the winner.
  always_comb begin
    any_req = req_a_i | req_b_i;
    sel_b   = req_b_i & (~req_a_i | rr_q);
    sel_op  = sel_b ? op_b_i : op_a_i;
    sel_dat = sel_b ? dat_b_i : dat_a_i;
    legal   = sel_op ? (depth_q != DW'(DEPTH)) : (depth_q != '0);
    top_idx = IW'(depth_q - DW'(1));
    depth_d = stk_w2_q ? (depth_q + DW'(1)) : (depth_q - DW'(1));
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= INIT0;
      rr_q      <= 1'b0;
      sel_b_q   <= 1'b0;
      ack_a_q   <= 1'b0;
      ack_b_q   <= 1'b0;
      err_a_q   <= 1'b0;
      err_b_q   <= 1'b0;
      rdat_q    <= '0;
      stk_w2_q  <= 1'b0;
      stk_w1_q  <= 1'b0;
      stk_din_q <= '0;
      stk_clk_q <= 1'b0;
      stk_rst_q <= 1'b0;
      depth_q   <= '0;
    end else begin
      ack_a_q <= 1'b0;
      ack_b_q <= 1'b0;
      err_a_q <= 1'b0;
      err_b_q <= 1'b0;
      case (state_q)
        // Strobe rises for one cycle, then falls on INIT1 entry while stk_rst is still low.
        INIT0: begin
          if (!stk_clk_q) begin
            stk_clk_q <= 1'b1;
          end else begin
            stk_clk_q <= 1'b0;
            state_q   <= INIT1;
          end
        end
        INIT1: begin
          stk_rst_q <= 1'b1;
          state_q   <= IDLE;
        end
        IDLE: begin
`ifdef STACK_ARB_CLR_EN
          if (clr_i) begin
            stk_rst_q <= 1'b0;
            depth_q   <= '0;
            rdat_q    <= '0;
            state_q   <= INIT0;
          end else
`endif
          if (any_req) begin
            sel_b_q <= sel_b;
            if (legal) begin
              stk_w2_q  <= sel_op;
              stk_w1_q  <= ~sel_op;
              stk_din_q <= sel_dat;
              if (!sel_op) begin
                rdat_q <= rows[top_idx];
              end
              state_q <= SETUP;
            end else begin
              err_a_q <= ~sel_b;
              err_b_q <= sel_b;
              rr_q    <= ~sel_b;
              state_q <= REJ;
            end
          end
        end
        SETUP: begin
          stk_clk_q <= 1'b1;
          state_q   <= STROBE;
        end
        // Falling strobe: the stack acts now, so bookkeeping and the ack go with it.
        STROBE: begin
          stk_clk_q <= 1'b0;
          ack_a_q   <= ~sel_b_q;
          ack_b_q   <= sel_b_q;
          depth_q   <= depth_d;
          rr_q      <= ~sel_b_q;
          state_q   <= HOLD;
        end
        HOLD: begin
          stk_w2_q <= 1'b0;
          stk_w1_q <= 1'b0;
          state_q  <= IDLE;
        end
        REJ: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= INIT0;
        end
      endcase
    end
  end

  assign ack_a_o   = ack_a_q;
  assign ack_b_o   = ack_b_q;
  assign err_a_o   = err_a_q;
  assign err_b_o   = err_b_q;
  assign rdat_o    = rdat_q;
  assign stk_w2_o  = stk_w2_q;
  assign stk_w1_o  = stk_w1_q;
  assign stk_din_o = stk_din_q;
  assign stk_clk_o = stk_clk_q;
  assign stk_rst_o = stk_rst_q;
  assign depth_o   = depth_q;
  assign full_o    = (depth_q == DW'(DEPTH));
  assign empty_o   = (depth_q == '0);

endmodule

// File: tb/tb_stack_arb.sv
// Bench for stack_arb: behavioural stack device, queue-based reference model, per-cycle compare.
module tb_stack_arb;
  localparam int WIDTH = 4;
  localparam int DEPTH = 4;
  localparam int DW    = $clog2(DEPTH + 1);

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic req_a = 0, req_b = 0, op_a = 0, op_b = 0, clr = 0;
  logic [WIDTH-1:0] dat_a = '0, dat_b = '0;
  logic ack_a, ack_b, err_a, err_b;
  logic [WIDTH-1:0] rdat, stk_din;
  logic [DEPTH*WIDTH-1:0] stk_rows;
  logic stk_w2, stk_w1, stk_clk, stk_rst, full, empty;
  logic [DW-1:0] depth;

  stack_arb #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .req_a_i(req_a), .req_b_i(req_b), .op_a_i(op_a), .op_b_i(op_b),
    .dat_a_i(dat_a), .dat_b_i(dat_b),
    .ack_a_o(ack_a), .ack_b_o(ack_b), .err_a_o(err_a), .err_b_o(err_b),
    .rdat_o(rdat), .stk_rows_i(stk_rows),
    .stk_w2_o(stk_w2), .stk_w1_o(stk_w1), .stk_din_o(stk_din),
    .stk_clk_o(stk_clk), .stk_rst_o(stk_rst),
    .depth_o(depth), .full_o(full), .empty_o(empty), .clr_i(clr)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Stack device: acts on the falling strobe.
  logic [WIDTH-1:0] dev_row [DEPTH];
  int dev_ptr = 0;
  bit dev_over = 0, dev_under = 0;
  int n_pulse = 0;
  always @(negedge stk_clk) begin
    if (!stk_rst) begin
      for (int i = 0; i < DEPTH; i++) dev_row[i] = '0;
      dev_ptr = 0; dev_over = 0; dev_under = 0;
    end else if (stk_w2) begin
      if (dev_ptr == DEPTH) dev_over = 1;
      else begin dev_row[dev_ptr] = stk_din; dev_ptr++; end
    end else if (stk_w1) begin
      if (dev_ptr == 0) dev_under = 1;
      else dev_ptr--;
    end
  end
  always @(posedge stk_clk) n_pulse++;
  always_comb begin
    stk_rows = '0;
    for (int i = 0; i < DEPTH; i++) stk_rows[i*WIDTH +: WIDTH] = dev_row[i];
  end

  // Reference model: stack contents as a queue, outcomes scheduled by cycle number.
  logic [WIDTH-1:0] ref_q [$];
  bit ack_a_at [int], ack_b_at [int], err_a_at [int], err_b_at [int];
  int dep_at [int];
  logic [WIDTH-1:0] rdat_at [int];
  int m_depth = 0, m_pulses = 0, rdat_from = 0;
  logic [WIDTH-1:0] m_rdat = '0;
  bit m_rr = 0;
  string log_s = "";

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    ref_q.delete();
    ack_a_at.delete(); ack_b_at.delete(); err_a_at.delete(); err_b_at.delete();
    dep_at.delete(); rdat_at.delete();
    m_depth = 0; m_rdat = '0; m_rr = 0; rdat_from = 0;
  endtask

  always @(negedge clk) begin
    if (dep_at.exists(cyc)) m_depth = dep_at[cyc];
    if (rdat_at.exists(cyc)) m_rdat = rdat_at[cyc];
    chk("ack_a", 32'(ack_a), 32'(ack_a_at.exists(cyc)));
    chk("ack_b", 32'(ack_b), 32'(ack_b_at.exists(cyc)));
    chk("err_a", 32'(err_a), 32'(err_a_at.exists(cyc)));
    chk("err_b", 32'(err_b), 32'(err_b_at.exists(cyc)));
    chk("depth", 32'(depth), 32'(m_depth));
    chk("full", 32'(full), 32'(m_depth == DEPTH));
    chk("empty", 32'(empty), 32'(m_depth == 0));
    if (cyc >= rdat_from) chk("rdat", 32'(rdat), 32'(m_rdat));
    chk("stack_flags", {30'd0, dev_over, dev_under}, 32'd0);
    if (ack_a) log_s = {log_s, "A"};
    if (ack_b) log_s = {log_s, "B"};
    if (err_a) log_s = {log_s, "a"};
    if (err_b) log_s = {log_s, "b"};
  end

  // Called #1 after a posedge with the DUT about to sample in IDLE.
  task automatic issue(input bit ra, input bit oa, input logic [WIDTH-1:0] da,
                       input bit rb, input bit ob, input logic [WIDTH-1:0] db);
    bit pa, pb, sb, op, legal;
    logic [WIDTH-1:0] d;
    int k;
    pa = ra; pb = rb;
    req_a = ra; op_a = oa; dat_a = da;
    req_b = rb; op_b = ob; dat_b = db;
    while (pa || pb) begin
      k = cyc;
      sb = pb && (!pa || m_rr);
      op = sb ? ob : oa;
      d  = sb ? db : da;
      legal = op ? (ref_q.size() < DEPTH) : (ref_q.size() > 0);
      m_rr = !sb;
      if (legal) begin
        if (op) ref_q.push_back(d);
        else begin rdat_at[k+3] = ref_q.pop_back(); rdat_from = k + 3; end
        dep_at[k+3] = ref_q.size();
        if (sb) ack_b_at[k+3] = 1; else ack_a_at[k+3] = 1;
        m_pulses++;
        repeat (4) @(posedge clk);
      end else begin
        if (sb) err_b_at[k+1] = 1; else err_a_at[k+1] = 1;
        repeat (2) @(posedge clk);
      end
      #1;
      if (sb) begin pb = 0; req_b = 0; end
      else begin pa = 0; req_a = 0; end
    end
  endtask

  task automatic init_seq();
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    chk("init0_clk", 32'(stk_clk), 32'd1);
    chk("init0_rst", 32'(stk_rst), 32'd0);
    @(posedge clk); #1;
    chk("init1_clk", 32'(stk_clk), 32'd0);
    chk("init1_rst", 32'(stk_rst), 32'd0);
    @(posedge clk); #1;
    chk("idle_rst", 32'(stk_rst), 32'd1);
    chk("idle_depth", 32'(depth), 32'd0);
    chk("idle_empty", 32'(empty), 32'd1);
    chk("dev_cleared", 32'(dev_ptr), 32'd0);
    m_pulses++;
  endtask

  initial begin
    int p0, k;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_clk", 32'(stk_clk), 32'd0);
    chk("rst_stkrst", 32'(stk_rst), 32'd0);
    chk("rst_cmd", {30'd0, stk_w2, stk_w1}, 32'd0);
    chk("rst_din", 32'(stk_din), 32'd0);
    init_seq();

    // A fills the stack.
    issue(1, 1, 4'h3, 0, 0, 4'h0);
    issue(1, 1, 4'h5, 0, 0, 4'h0);
    issue(1, 1, 4'h9, 0, 0, 4'h0);
    issue(1, 1, 4'hC, 0, 0, 4'h0);
    chk("fill_depth", 32'(depth), 32'd4);
    chk("fill_full", 32'(full), 32'd1);
    chk("fill_rows", 32'(stk_rows), 32'hC953);

    // B drains it, then underflows.
    issue(0, 0, 4'h0, 1, 0, 4'h0);
    chk("pop1_rdat", 32'(rdat), 32'hC);
    chk("pop1_depth", 32'(depth), 32'd3);
    issue(0, 0, 4'h0, 1, 0, 4'h0);
    issue(0, 0, 4'h0, 1, 0, 4'h0);
    issue(0, 0, 4'h0, 1, 0, 4'h0);
    chk("pop4_rdat", 32'(rdat), 32'h3);
    p0 = n_pulse;
    issue(0, 0, 4'h0, 1, 0, 4'h0);
    chk("rej_no_pulse", 32'(n_pulse), 32'(p0));
    chk("rej_rdat", 32'(rdat), 32'h3);

    // Simultaneous requests alternate; rejections still move the pointer.
    log_s = "";
    issue(1, 1, 4'h1, 1, 1, 4'h2);
    issue(1, 1, 4'h3, 1, 1, 4'h4);
    issue(1, 1, 4'h5, 1, 1, 4'h6);
    issue(1, 0, 4'h0, 1, 0, 4'h0);
    n_tests++;
    if (log_s != "ABABabAB") begin
      n_fail++;
      $display("FAIL grant_order: got %s, expected ABABabAB", log_s);
    end
    chk("alt_rdat", 32'(rdat), 32'h3);
    chk("alt_depth", 32'(depth), 32'd2);

    // Reset while the strobe is high.
    req_a = 1; op_a = 1; dat_a = 4'h7;
    @(posedge clk); #1;
    chk("mid_setup_w2", 32'(stk_w2), 32'd1);
    @(posedge clk); #1;
    chk("mid_strobe_clk", 32'(stk_clk), 32'd1);
    rst_n = 1'b0;
    model_reset();
    m_pulses++;
    #1;
    chk("mid_rst_clk", 32'(stk_clk), 32'd0);
    chk("mid_rst_cmd", {30'd0, stk_w2, stk_w1}, 32'd0);
    chk("mid_rst_stkrst", 32'(stk_rst), 32'd0);
    chk("mid_rst_depth", 32'(depth), 32'd0);
    req_a = 0;
    init_seq();

    // Clear request alongside a push.
    issue(1, 1, 4'h1, 0, 0, 4'h0);
    issue(1, 1, 4'h2, 0, 0, 4'h0);
`ifdef STACK_ARB_CLR_EN
    k = cyc;
    clr = 1; req_a = 1; op_a = 1; dat_a = 4'h8;
    ref_q.delete();
    dep_at[k+1] = 0; rdat_at[k+1] = '0; rdat_from = k + 1;
    m_pulses++;
    @(posedge clk); #1;
    chk("clr_stkrst_low", 32'(stk_rst), 32'd0);
    clr = 0;
    repeat (3) @(posedge clk); #1;
    chk("clr_stkrst_high", 32'(stk_rst), 32'd1);
    chk("clr_dev_ptr", 32'(dev_ptr), 32'd0);
    issue(1, 1, 4'h8, 0, 0, 4'h0);
    chk("clr_then_push_depth", 32'(depth), 32'd1);
    chk("clr_then_push_row", 32'(stk_rows[3:0]), 32'h8);
`else
    k = cyc;
    clr = 1;
    issue(1, 1, 4'h8, 0, 0, 4'h0);
    clr = 0;
    chk("clr_ignored_depth", 32'(depth), 32'd3);
    chk("clr_ignored_row", 32'(stk_rows[11:8]), 32'h8);
`endif

    repeat (2) @(posedge clk); #1;
    chk("pulse_count", 32'(n_pulse), 32'(m_pulses));
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
